// File: rtl/fact_pkg.sv
// Shared constants and the FSM state enumeration for the factorial scheduler.
package fact_pkg;
   localparam int unsigned N_W_DEF   = 32;
   localparam int unsigned RES_W_DEF = 64;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to ptr.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);
   always_comb begin
      grant = req;
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
   end
endmodule

// File: rtl/fact_sched.sv
// Two-requester factorial scheduler: one shared multiplier, one calculation in
// flight, saturating result with overflow flag.
module fact_sched
   import fact_pkg::*;
#(
   parameter int unsigned N_W   = N_W_DEF,
   parameter int unsigned RES_W = RES_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   input  logic [2*N_W-1:0] req_n,
   output logic [1:0]       req_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [RES_W-1:0] rsp_fact,
   output logic             rsp_ovf
);
   state_t             state, state_nxt;
   logic [RES_W-1:0]   acc, acc_nxt;
   logic [N_W-1:0]     cnt, cnt_nxt;
   logic               ovf, ovf_nxt;
   logic               id, id_nxt;
   logic               ptr, ptr_nxt;

   logic [1:0]           grant;
   logic [1:0]           take;
   logic                 take_id;
   logic [N_W-1:0]       n_sel;
   logic [RES_W+N_W-1:0] prod;
   logic [N_W-1:0]       cnt_dec;

   rr_arb2 u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   assign take    = req_valid & req_ready;
   assign take_id = take[1];
   assign n_sel   = take_id ? req_n[N_W +: N_W] : req_n[0 +: N_W];
   assign prod    = {{N_W{1'b0}}, acc} * {{RES_W{1'b0}}, cnt};
   assign cnt_dec = cnt - N_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         id    <= 1'b0;
         ptr   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
         id    <= id_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      id_nxt    = id;
      ptr_nxt   = ptr;
      req_ready = '0;
      case (state)
         IDLE: begin
            req_ready = grant;
            if (|take) begin
               id_nxt    = take_id;
               cnt_nxt   = n_sel;
               acc_nxt   = RES_W'(1);
               ovf_nxt   = 1'b0;
               ptr_nxt   = ~take_id;
               state_nxt = (n_sel <= N_W'(1)) ? RESP : CALC;
            end
         end
         CALC: begin
            // Any bit above RES_W means the true product no longer fits.
            if (|prod[RES_W +: N_W]) begin
               ovf_nxt   = 1'b1;
               acc_nxt   = '1;
               state_nxt = RESP;
            end else begin
               acc_nxt = prod[RES_W-1:0];
               cnt_nxt = cnt_dec;
               if (cnt_dec == N_W'(1)) state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_valid = (state == RESP);
   assign rsp_fact  = rsp_valid ? acc : '0;
   assign rsp_id    = rsp_valid & id;
   assign rsp_ovf   = rsp_valid & ovf;
endmodule

// File: tb/tb_fact_sched.sv
// Self-checking bench for fact_sched against a saturating-factorial reference model.
module tb_fact_sched;
   localparam int unsigned NW = 32;
   localparam int unsigned RW = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [2*NW-1:0] req_n = '0;
   logic [1:0]      req_ready;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic            rsp_id;
   logic [RW-1:0]   rsp_fact;
   logic            rsp_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   fact_sched #(.N_W(NW), .RES_W(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_n     (req_n),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_fact  (rsp_fact),
      .rsp_ovf   (rsp_ovf)
   );

   always #5 clk = ~clk;

   // Reference: N! multiplied in descending order, saturating; steps = edges after accept.
   function automatic void model(input longint unsigned n, output logic [63:0] f,
                                 output bit ovf, output int steps);
      f = 64'd1; ovf = 1'b0; steps = 0;
      for (longint unsigned k = n; k >= 2; k--) begin
         steps++;
         if (f > 64'hFFFF_FFFF_FFFF_FFFF / k) begin
            ovf = 1'b1;
            f = '1;
            break;
         end
         f = f * k;
      end
   endfunction

   task automatic accept(input int id, input logic [NW-1:0] n, output bit to);
      int k;
      @(negedge clk);
      req_valid[id] = 1'b1;
      req_n[id*NW +: NW] = n;
      #1;
      k = 0;
      while (!req_ready[id] && k < 100) begin
         @(negedge clk);
         #1;
         k++;
      end
      to = !req_ready[id];
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output bit to);
      @(negedge clk);
      lat = 0;
      while (!rsp_valid && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      to = !rsp_valid;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic run_check(input string name, input int id, input logic [NW-1:0] n);
      logic [63:0] ef; bit eo; int es; int lat; bit to1, to2;
      model(longint'(n), ef, eo, es);
      accept(id, n, to1);
      wait_rsp(lat, to2);
      n_tests++;
      if (to1 || to2) begin
         n_fail++;
         $display("FAIL %s timeout: accept_to=%0b rsp_to=%0b", name, to1, to2);
      end
      n_tests++;
      if (rsp_fact !== ef || rsp_ovf !== eo || rsp_id !== id[0]) begin
         n_fail++;
         $display("FAIL %s result: got fact=%0d ovf=%0b id=%0b, want fact=%0d ovf=%0b id=%0b",
                  name, rsp_fact, rsp_ovf, rsp_id, ef, eo, id[0]);
      end
      n_tests++;
      if (lat !== es) begin
         n_fail++;
         $display("FAIL %s latency: got %0d, want %0d", name, lat, es);
      end
      finish_rsp();
      n_tests++;
      if (rsp_valid !== 1'b0 || rsp_fact !== '0) begin
         n_fail++;
         $display("FAIL %s drop: got valid=%0b fact=%0d, want 0/0", name, rsp_valid, rsp_fact);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_ovf, req_ready} !== 5'b0 || rsp_fact !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%0b id=%0b ovf=%0b ready=%b fact=%0d, want zeros",
                  rsp_valid, rsp_id, rsp_ovf, req_ready, rsp_fact);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_check("n5", 0, 32'd5);
      run_check("n0", 0, 32'd0);
      run_check("n1", 1, 32'd1);
   endtask

   task automatic test_boundary();
      run_check("n20", 0, 32'd20);
      run_check("n21", 1, 32'd21);
      run_check("n1000", 0, 32'd1000);
   endtask

   task automatic test_round_robin();
      int got_id[$]; logic [63:0] got_f[$]; int k;
      bit exp_id [3] = '{1'b0, 1'b1, 1'b0};
      logic [63:0] exp_f [3] = '{64'd6, 64'd24, 64'd6};
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_n = {32'd4, 32'd3};
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      k = 0;
      while (got_id.size() < 3 && k < 200) begin
         @(negedge clk);
         if (rsp_valid) begin
            got_id.push_back(int'(rsp_id));
            got_f.push_back(rsp_fact);
         end
         k++;
      end
      req_valid = 2'b00;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      n_tests++;
      if (got_id.size() != 3) begin
         n_fail++;
         $display("FAIL rr_count: got %0d responses, want 3", got_id.size());
      end
      for (int i = 0; i < got_id.size(); i++) begin
         n_tests++;
         if (got_id[i] != int'(exp_id[i]) || got_f[i] !== exp_f[i]) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got id=%0d fact=%0d, want id=%0d fact=%0d",
                     i, got_id[i], got_f[i], exp_id[i], exp_f[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int lat; bit to1, to2; int bad;
      accept(0, 32'd4, to1);
      wait_rsp(lat, to2);
      n_tests++;
      if (to1 || to2) begin
         n_fail++;
         $display("FAIL bp_timeout: accept_to=%0b rsp_to=%0b", to1, to2);
      end
      req_n = {32'd2, 32'd2};
      req_valid = 2'b11;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_fact !== 64'd24 || rsp_id !== 1'b0 ||
             rsp_ovf !== 1'b0 || req_ready !== 2'b00) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d unstable cycles (last valid=%0b fact=%0d id=%0b ready=%b), want 0",
                  bad, rsp_valid, rsp_fact, rsp_id, req_ready);
      end
      req_valid = 2'b00;
      finish_rsp();
   endtask

   task automatic test_reset_mid();
      bit to1; int seen;
      accept(0, 32'd10, to1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (to1 || rsp_valid !== 1'b0 || rsp_fact !== '0 || rsp_id !== 1'b0 || rsp_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got to=%0b valid=%0b fact=%0d id=%0b ovf=%0b, want 0",
                  to1, rsp_valid, rsp_fact, rsp_id, rsp_ovf);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL mid_reset_no_rsp: got %0d valid cycles, want 0", seen);
      end
      run_check("after_reset_n6", 0, 32'd6);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         int id; logic [NW-1:0] n;
         id = int'($urandom_range(0, 1));
         n = ($urandom_range(0, 7) == 0) ? NW'($urandom_range(21, 300)) : NW'($urandom_range(0, 22));
         run_check($sformatf("rand%0d_n%0d", i, n), id, n);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
